// File: rtl/dct_pkg.sv
// Shared definitions for the DCT front-end ping-pong scheduler:
// per-engine state encoding, default fftpts width and engine indices.
package dct_pkg;

    localparam int WPTS = 12;
    localparam int PING = 0;
    localparam int PONG = 1;

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_FILLING  = 2'd1,
        ST_FULL     = 2'd2,
        ST_DRAINING = 2'd3
    } dct_state_e;

endpackage

// File: rtl/dct_pp_eng_fsm.sv
// One reorder engine's frame state: fill/drain transitions and the fftpts
// value latched at the start of the frame currently held by the engine.
module dct_pp_eng_fsm
    import dct_pkg::*;
#(
    parameter int wPts = WPTS
) (
    input  logic            clk,
    input  logic            rst_sync,
    input  logic            beat_en,
    input  logic            sop,
    input  logic            eop,
    input  logic [wPts-1:0] fftpts_in,
    input  logic            grant,
    input  logic            drain_done,
    output dct_state_e      state,
    output dct_state_e      state_nxt,
    output logic [wPts-1:0] pts
);

    dct_state_e      st_q, st_d;
    logic [wPts-1:0] pts_q, pts_d;

    always_comb begin
        st_d  = st_q;
        pts_d = pts_q;
        case (st_q)
            ST_EMPTY: begin
                // A beat without sop is dropped by the scheduler; only sop opens a frame.
                if (beat_en && sop) begin
                    pts_d = fftpts_in;
                    st_d  = eop ? ST_FULL : ST_FILLING;
                end
            end
            ST_FILLING: begin
                if (beat_en) begin
                    if (sop) begin
                        pts_d = fftpts_in;
                    end
                    if (eop) begin
                        st_d = ST_FULL;
                    end
                end
            end
            ST_FULL: begin
                if (grant) begin
                    st_d = ST_DRAINING;
                end
            end
            ST_DRAINING: begin
                if (drain_done) begin
                    st_d = ST_EMPTY;
                end
            end
            default: st_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            st_q  <= ST_EMPTY;
            pts_q <= '0;
        end else begin
            st_q  <= st_d;
            pts_q <= pts_d;
        end
    end

    assign state     = st_q;
    assign state_nxt = st_d;
    assign pts       = pts_q;

endmodule

// File: rtl/dct_pp_sched.sv
// Frame-level ping-pong scheduler: steers input frames to a free reorder
// engine and grants filled engines to the FFT strictly in arrival order.
module dct_pp_sched
    import dct_pkg::*;
#(
    parameter int wCnt = 16,
    parameter int wPts = WPTS
) (
    input  logic            clk,
    input  logic            rst_sync,
    input  logic            sink_valid,
    input  logic            sink_sop,
    input  logic            sink_eop,
    output logic            sink_ready,
    input  logic [wPts-1:0] fftpts_in,
    output logic [1:0]      eng_sink_valid,
    input  logic [1:0]      eng_sink_ready,
    output logic            sink_sel,
    input  logic [1:0]      eng_src_valid,
    input  logic [1:0]      eng_src_eop,
    output logic [1:0]      eng_src_ready,
    output logic            src_sel,
    input  logic            fft_ready,
    output logic [wPts-1:0] fftpts_out,
    output logic [3:0]      eng_state,
    output logic            frame_err,
    output logic [wCnt-1:0] frm_cnt_in,
    output logic [wCnt-1:0] frm_cnt_out
);

    logic            sink_sel_q, sink_sel_d;
    logic            src_sel_q, src_sel_d;
    logic            sink_ready_q, sink_ready_d;
    logic            frame_err_q, frame_err_d;
    logic [wPts-1:0] beat_cnt_q, beat_cnt_d;
    logic [wCnt-1:0] frm_cnt_in_q, frm_cnt_in_d;
    logic [wCnt-1:0] frm_cnt_out_q, frm_cnt_out_d;

    dct_state_e      st     [2];
    dct_state_e      st_nxt [2];
    logic [wPts-1:0] pts    [2];
    logic            acc;
    logic [1:0]      beat_en, grant, src_rdy, drain_done, fill_close;
    dct_state_e      cur_st;

    assign acc = sink_valid & sink_ready_q;

    for (genvar e = 0; e < 2; e++) begin : g_eng
        assign beat_en[e]        = acc & (sink_sel_q == 1'(e));
        assign grant[e]          = (src_sel_q == 1'(e));
        // Gated by reset so no drain handshake is offered while state is being cleared.
        assign src_rdy[e]        = fft_ready & grant[e] & (st[e] == ST_DRAINING) & ~rst_sync;
        assign drain_done[e]     = eng_src_valid[e] & eng_src_eop[e] & src_rdy[e];
        assign fill_close[e]     = ((st[e] == ST_EMPTY) || (st[e] == ST_FILLING)) &&
                                   (st_nxt[e] == ST_FULL);
        assign eng_sink_valid[e] = beat_en[e] &
                                   ((st[e] == ST_FILLING) | ((st[e] == ST_EMPTY) & sink_sop));

        dct_pp_eng_fsm #(.wPts(wPts)) u_fsm (
            .clk        (clk),
            .rst_sync   (rst_sync),
            .beat_en    (beat_en[e]),
            .sop        (sink_sop),
            .eop        (sink_eop),
            .fftpts_in  (fftpts_in),
            .grant      (grant[e]),
            .drain_done (drain_done[e]),
            .state      (st[e]),
            .state_nxt  (st_nxt[e]),
            .pts        (pts[e])
        );
    end

    always_comb begin
        cur_st        = st[sink_sel_q];
        beat_cnt_d    = beat_cnt_q;
        frame_err_d   = 1'b0;
        sink_sel_d    = sink_sel_q ^ (|fill_close);
        src_sel_d     = src_sel_q ^ (|drain_done);
        frm_cnt_in_d  = frm_cnt_in_q;
        frm_cnt_out_d = frm_cnt_out_q;
        if (|fill_close) begin
            frm_cnt_in_d = frm_cnt_in_q + wCnt'(1);
        end
        if (|drain_done) begin
            frm_cnt_out_d = frm_cnt_out_q + wCnt'(1);
        end

        // Framing/length checks on the beat just accepted into the receiving engine.
        if (acc) begin
            if (sink_sop) begin
                if (cur_st == ST_FILLING) begin
                    frame_err_d = 1'b1;
                end
                if ((cur_st == ST_EMPTY) || (cur_st == ST_FILLING)) begin
                    beat_cnt_d = wPts'(1);
                    if (sink_eop && (fftpts_in != wPts'(1))) begin
                        frame_err_d = 1'b1;
                    end
                end
            end else if (cur_st == ST_EMPTY) begin
                frame_err_d = 1'b1;
            end else if (cur_st == ST_FILLING) begin
                beat_cnt_d = beat_cnt_q + wPts'(1);
                if (sink_eop && ((beat_cnt_q + wPts'(1)) != pts[sink_sel_q])) begin
                    frame_err_d = 1'b1;
                end
            end
        end

        sink_ready_d = eng_sink_ready[sink_sel_d] &
                       ((st_nxt[sink_sel_d] == ST_EMPTY) || (st_nxt[sink_sel_d] == ST_FILLING));
    end

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            sink_sel_q    <= 1'b0;
            src_sel_q     <= 1'b0;
            sink_ready_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            beat_cnt_q    <= '0;
            frm_cnt_in_q  <= '0;
            frm_cnt_out_q <= '0;
        end else begin
            sink_sel_q    <= sink_sel_d;
            src_sel_q     <= src_sel_d;
            sink_ready_q  <= sink_ready_d;
            frame_err_q   <= frame_err_d;
            beat_cnt_q    <= beat_cnt_d;
            frm_cnt_in_q  <= frm_cnt_in_d;
            frm_cnt_out_q <= frm_cnt_out_d;
        end
    end

    assign sink_ready    = sink_ready_q;
    assign sink_sel      = sink_sel_q;
    assign src_sel       = src_sel_q;
    assign eng_src_ready = src_rdy;
    assign fftpts_out    = pts[src_sel_q];
    assign eng_state     = {st[PONG], st[PING]};
    assign frame_err     = frame_err_q;
    assign frm_cnt_in    = frm_cnt_in_q;
    assign frm_cnt_out   = frm_cnt_out_q;

endmodule

// File: tb/tb_dct_pp_sched.sv
// Directed bench for dct_pp_sched: framing, ordering, back-pressure,
// error pulses and mid-drain reset, with hand-computed expectations.
module tb_dct_pp_sched;

    logic        clk = 1'b0;
    logic        rst_sync;
    logic        sink_valid, sink_sop, sink_eop, sink_ready;
    logic [11:0] fftpts_in;
    logic [1:0]  eng_sink_valid, eng_sink_ready;
    logic        sink_sel;
    logic [1:0]  eng_src_valid, eng_src_eop, eng_src_ready;
    logic        src_sel, fft_ready;
    logic [11:0] fftpts_out;
    logic [3:0]  eng_state;
    logic        frame_err;
    logic [15:0] frm_cnt_in, frm_cnt_out;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dct_pp_sched #(.wCnt(16), .wPts(12)) dut (
        .clk            (clk),
        .rst_sync       (rst_sync),
        .sink_valid     (sink_valid),
        .sink_sop       (sink_sop),
        .sink_eop       (sink_eop),
        .sink_ready     (sink_ready),
        .fftpts_in      (fftpts_in),
        .eng_sink_valid (eng_sink_valid),
        .eng_sink_ready (eng_sink_ready),
        .sink_sel       (sink_sel),
        .eng_src_valid  (eng_src_valid),
        .eng_src_eop    (eng_src_eop),
        .eng_src_ready  (eng_src_ready),
        .src_sel        (src_sel),
        .fft_ready      (fft_ready),
        .fftpts_out     (fftpts_out),
        .eng_state      (eng_state),
        .frame_err      (frame_err),
        .frm_cnt_in     (frm_cnt_in),
        .frm_cnt_out    (frm_cnt_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic beat(input logic sop, input logic eop, input logic [11:0] pts,
                        input logic [1:0] esv);
        sink_valid = 1'b1;
        sink_sop   = sop;
        sink_eop   = eop;
        fftpts_in  = pts;
        #1;
        chk("eng_sink_valid", 32'(eng_sink_valid), 32'(esv));
        step();
    endtask

    task automatic idle_sink();
        sink_valid = 1'b0;
        sink_sop   = 1'b0;
        sink_eop   = 1'b0;
    endtask

    task automatic send_frame(input int e, input int n, input logic [11:0] pts);
        for (int i = 0; i < n; i++) begin
            beat(i == 0, i == n - 1, pts, (e == 1) ? 2'b10 : 2'b01);
        end
        idle_sink();
    endtask

    task automatic drain(input int e, input int n);
        for (int i = 0; i < n; i++) begin
            eng_src_valid[e] = 1'b1;
            eng_src_eop[e]   = (i == n - 1);
            #1;
            chk("eng_src_ready", 32'(eng_src_ready), (e == 1) ? 32'h2 : 32'h1);
            step();
        end
        eng_src_valid = 2'b00;
        eng_src_eop   = 2'b00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected < 100000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_sync       = 1'b1;
        sink_valid     = 1'b0;
        sink_sop       = 1'b0;
        sink_eop       = 1'b0;
        fftpts_in      = 12'd0;
        eng_sink_ready = 2'b11;
        eng_src_valid  = 2'b00;
        eng_src_eop    = 2'b00;
        fft_ready      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        chk("rst_sink_ready", 32'(sink_ready), 32'h0);
        chk("rst_eng_state", 32'(eng_state), 32'h0);
        chk("rst_sink_sel", 32'(sink_sel), 32'h0);
        chk("rst_src_sel", 32'(src_sel), 32'h0);
        chk("rst_cnt_in", 32'(frm_cnt_in), 32'h0);
        chk("rst_fftpts_out", 32'(fftpts_out), 32'h0);
        rst_sync = 1'b0;
        step();
        chk("sink_ready_after_rst", 32'(sink_ready), 32'h1);

        // 8-point frame into ping, then drain
        send_frame(0, 8, 12'd8);
        chk("t1_state_full", 32'(eng_state), 32'h2);
        chk("t1_sink_sel", 32'(sink_sel), 32'h1);
        chk("t1_src_sel", 32'(src_sel), 32'h0);
        chk("t1_cnt_in", 32'(frm_cnt_in), 32'h1);
        chk("t1_err", 32'(frame_err), 32'h0);
        chk("t1_fftpts_out", 32'(fftpts_out), 32'h8);
        chk("t1_sink_ready", 32'(sink_ready), 32'h1);
        step();
        chk("t1_state_drain", 32'(eng_state), 32'h3);
        fft_ready = 1'b1;
        drain(0, 8);
        chk("t1_state_empty", 32'(eng_state), 32'h0);
        chk("t1_src_sel_after", 32'(src_sel), 32'h1);
        chk("t1_cnt_in_after", 32'(frm_cnt_in), 32'h1);
        chk("t1_cnt_out", 32'(frm_cnt_out), 32'h1);

        // Back-to-back 16-point frames with the FFT stalled
        rst_sync = 1'b1;
        step();
        rst_sync  = 1'b0;
        fft_ready = 1'b0;
        step();
        send_frame(0, 16, 12'd16);
        send_frame(1, 16, 12'd16);
        chk("t2_sink_ready_low", 32'(sink_ready), 32'h0);
        chk("t2_state_both", 32'(eng_state), 32'hB);
        chk("t2_sink_sel", 32'(sink_sel), 32'h0);
        step();
        chk("t2_sink_ready_hold", 32'(sink_ready), 32'h0);
        chk("t2_state_hold", 32'(eng_state), 32'hB);
        fft_ready = 1'b1;
        drain(0, 16);
        chk("t2_sink_ready_back", 32'(sink_ready), 32'h1);
        chk("t2_state_ping_empty", 32'(eng_state), 32'h8);
        chk("t2_src_sel", 32'(src_sel), 32'h1);
        chk("t2_cnt_in", 32'(frm_cnt_in), 32'h2);
        chk("t2_cnt_out_1", 32'(frm_cnt_out), 32'h1);
        step();
        chk("t2_state_pong_drain", 32'(eng_state), 32'hC);
        drain(1, 16);
        chk("t2_state_empty", 32'(eng_state), 32'h0);
        chk("t2_cnt_out_2", 32'(frm_cnt_out), 32'h2);
        chk("t2_src_sel_back", 32'(src_sel), 32'h0);

        // sop repeated at beat 5 of a 16-point frame
        for (int i = 0; i < 4; i++) begin
            beat(i == 0, 1'b0, 12'd16, 2'b01);
        end
        beat(1'b1, 1'b0, 12'd16, 2'b01);
        chk("t3_err_pulse", 32'(frame_err), 32'h1);
        chk("t3_state_filling", 32'(eng_state), 32'h1);
        beat(1'b0, 1'b0, 12'd16, 2'b01);
        chk("t3_err_clear", 32'(frame_err), 32'h0);
        for (int i = 0; i < 14; i++) begin
            beat(1'b0, i == 13, 12'd16, 2'b01);
        end
        idle_sink();
        chk("t3_err_none", 32'(frame_err), 32'h0);
        chk("t3_state_full", 32'(eng_state), 32'h2);
        chk("t3_cnt_in", 32'(frm_cnt_in), 32'h3);
        chk("t3_sink_sel", 32'(sink_sel), 32'h1);
        chk("t3_fftpts_out", 32'(fftpts_out), 32'h10);
        step();
        drain(0, 16);
        chk("t3_cnt_out", 32'(frm_cnt_out), 32'h3);
        chk("t3_src_sel", 32'(src_sel), 32'h1);

        // Short frame: eop at beat 7 with fftpts 8, into pong
        send_frame(1, 7, 12'd8);
        chk("t4_err_pulse", 32'(frame_err), 32'h1);
        chk("t4_state_full", 32'(eng_state), 32'h8);
        chk("t4_cnt_in", 32'(frm_cnt_in), 32'h4);
        chk("t4_sink_sel", 32'(sink_sel), 32'h0);
        step();
        chk("t4_err_one_cycle", 32'(frame_err), 32'h0);
        chk("t4_state_drain", 32'(eng_state), 32'hC);
        chk("t4_fftpts_out", 32'(fftpts_out), 32'h8);
        drain(1, 7);
        chk("t4_cnt_out", 32'(frm_cnt_out), 32'h4);
        chk("t4_src_sel", 32'(src_sel), 32'h0);
        chk("t4_state_empty", 32'(eng_state), 32'h0);

        // Beat without sop while empty, then a normal frame and a single-beat frame
        sink_valid = 1'b1;
        sink_sop   = 1'b0;
        sink_eop   = 1'b0;
        fftpts_in  = 12'd4;
        #1;
        chk("t5_drop_esv", 32'(eng_sink_valid), 32'h0);
        step();
        idle_sink();
        chk("t5_err_pulse", 32'(frame_err), 32'h1);
        chk("t5_state_empty", 32'(eng_state), 32'h0);
        chk("t5_sink_ready", 32'(sink_ready), 32'h1);
        send_frame(0, 4, 12'd4);
        chk("t5_err_none", 32'(frame_err), 32'h0);
        chk("t5_state_full", 32'(eng_state), 32'h2);
        chk("t5_sink_sel", 32'(sink_sel), 32'h1);
        send_frame(1, 1, 12'd1);
        chk("t5_single_state", 32'(eng_state), 32'hB);
        chk("t5_single_err", 32'(frame_err), 32'h0);
        chk("t5_single_sel", 32'(sink_sel), 32'h0);
        chk("t5_both_busy_ready", 32'(sink_ready), 32'h0);
        chk("t5_cnt_in", 32'(frm_cnt_in), 32'h6);

        // Reset while pong drains and ping fills
        drain(0, 4);
        chk("t6_state_pong_full", 32'(eng_state), 32'h8);
        chk("t6_sink_ready", 32'(sink_ready), 32'h1);
        chk("t6_cnt_out", 32'(frm_cnt_out), 32'h5);
        beat(1'b1, 1'b0, 12'd8, 2'b01);
        beat(1'b0, 1'b0, 12'd8, 2'b01);
        idle_sink();
        chk("t6_state_mixed", 32'(eng_state), 32'hD);
        rst_sync      = 1'b1;
        eng_src_valid = 2'b10;
        #1;
        chk("t6_no_src_ready_in_rst", 32'(eng_src_ready), 32'h0);
        step();
        eng_src_valid = 2'b00;
        chk("t6_rst_state", 32'(eng_state), 32'h0);
        chk("t6_rst_sink_sel", 32'(sink_sel), 32'h0);
        chk("t6_rst_src_sel", 32'(src_sel), 32'h0);
        chk("t6_rst_cnt_in", 32'(frm_cnt_in), 32'h0);
        chk("t6_rst_cnt_out", 32'(frm_cnt_out), 32'h0);
        chk("t6_rst_sink_ready", 32'(sink_ready), 32'h0);
        chk("t6_rst_fftpts_out", 32'(fftpts_out), 32'h0);
        rst_sync = 1'b0;
        step();
        send_frame(0, 2, 12'd2);
        chk("t6_fresh_state", 32'(eng_state), 32'h2);
        chk("t6_fresh_cnt_in", 32'(frm_cnt_in), 32'h1);
        chk("t6_fresh_sink_sel", 32'(sink_sel), 32'h1);
        chk("t6_fresh_err", 32'(frame_err), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
